// File: rtl/mem_stage_unit_pkg.sv
// rtl/mem_stage_unit_pkg.sv - bus layouts, widths and load-op encodings shared by the MEM stage
package mem_stage_unit_pkg;

    localparam int DEST_SIZE = 5;
    localparam int DATA_SIZE = 32;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } ld_op_e;

    // EX->ME payload, most significant field first
    typedef struct packed {
        logic                 syscall;
        logic                 ertn;
        logic                 res_from_mem;
        ld_op_e               ld_op;
        logic                 mem_req;
        logic [31:0]          pc;
        logic                 gr_we;
        logic [DEST_SIZE-1:0] dest;
        logic [DATA_SIZE-1:0] alu_result;
    } ex_me_bus_t;

    // ME->WB payload, most significant field first
    typedef struct packed {
        logic                 syscall;
        logic                 ertn;
        logic [31:0]          pc;
        logic                 gr_we;
        logic [DEST_SIZE-1:0] dest;
        logic [DATA_SIZE-1:0] final_result;
    } me_wb_bus_t;

    // bus widths are the sum of their fields
    localparam int EX_TO_ME_BUS_SIZE = $bits(ex_me_bus_t);
    localparam int ME_TO_WB_BUS_SIZE = $bits(me_wb_bus_t);

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed byte/halfword of a load response and extends it
module mem_load_align
    import mem_stage_unit_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // lane select by address, then sign or zero extension by op; halfwords use addr[1] only
    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_BU:   data = {24'd0, byte_sel};
            LD_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM pipeline stage with SRAM response wait, buffering and flush discard (option: ME_LOAD_FWD_EN)
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int DISCARD_CNT_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ME_Allow_in,
    input  logic                         EX_to_ME_Valid,
    input  logic [EX_TO_ME_BUS_SIZE-1:0] EX_to_ME_Bus,
    input  logic                         WB_Allow_in,
    output logic                         ME_to_WB_Valid,
    output logic [ME_TO_WB_BUS_SIZE-1:0] ME_to_WB_Bus,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         ertn_flush,
    input  logic                         excp_flush,
    output logic [4:0]                   ME_dest,
    output logic [31:0]                  ME_Forward_Res,
    output logic                         ME_ld_block
);

    ex_me_bus_t               bus_q, bus_d;
    logic                     me_valid_q, me_valid_d;
    logic                     buf_valid_q, buf_valid_d;
    logic [31:0]              buf_q, buf_d;
    logic [DISCARD_CNT_W-1:0] discard_cnt_q, discard_cnt_d;

    logic        flush, ready_go, resp_own, resp_drop, leave, cnt_inc, cnt_full;
    logic [31:0] load_data, final_result;
    me_wb_bus_t  wb_bus;

    // handshake terms and classification of an arriving response (stale vs. ours)
    always_comb begin
        flush          = ertn_flush | excp_flush;
        resp_drop      = data_sram_data_ok & (discard_cnt_q != '0);
        resp_own       = data_sram_data_ok & (discard_cnt_q == '0);
        ready_go       = !bus_q.mem_req | buf_valid_q | resp_own;
        ME_Allow_in    = !me_valid_q | (ready_go & WB_Allow_in);
        ME_to_WB_Valid = me_valid_q & ready_go & !flush;
        leave          = ME_to_WB_Valid & WB_Allow_in;
        cnt_inc        = flush & me_valid_q & bus_q.mem_req & !buf_valid_q & !resp_own;
        cnt_full       = &discard_cnt_q;
    end

    // next state: capture from EX, park early response data, count responses owed to flushed instructions
    always_comb begin
        me_valid_d    = me_valid_q;
        bus_d         = bus_q;
        buf_valid_d   = buf_valid_q;
        buf_d         = buf_q;
        discard_cnt_d = discard_cnt_q;
        if (ME_Allow_in) begin
            me_valid_d = EX_to_ME_Valid;
            if (EX_to_ME_Valid) begin
                bus_d = ex_me_bus_t'(EX_to_ME_Bus);
            end
        end
        if (flush) begin
            me_valid_d = 1'b0;
        end
        if (resp_own & me_valid_q & bus_q.mem_req & !buf_valid_q & !WB_Allow_in) begin
            buf_valid_d = 1'b1;
            buf_d       = data_sram_rdata;
        end
        if (leave | flush) begin
            buf_valid_d = 1'b0;
        end
        if (cnt_inc & !resp_drop) begin
            if (!cnt_full) begin
                discard_cnt_d = discard_cnt_q + DISCARD_CNT_W'(1);
            end
        end else if (resp_drop & !cnt_inc) begin
            discard_cnt_d = discard_cnt_q - DISCARD_CNT_W'(1);
        end
    end

    // control state is reset; payload and buffered data are only meaningful while their valids are set
    always_ff @(posedge clk) begin
        if (reset) begin
            me_valid_q    <= 1'b0;
            buf_valid_q   <= 1'b0;
            discard_cnt_q <= '0;
        end else begin
            me_valid_q    <= me_valid_d;
            buf_valid_q   <= buf_valid_d;
            discard_cnt_q <= discard_cnt_d;
        end
        bus_q <= bus_d;
        buf_q <= buf_d;
    end

    // another cancelled response while the counter is saturated would be misrouted
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(cnt_inc && !resp_drop && cnt_full));
        end
    end

    mem_load_align u_load_align (
        .ld_op (bus_q.ld_op),
        .addr  (bus_q.alu_result[1:0]),
        .rdata (buf_valid_q ? buf_q : data_sram_rdata),
        .data  (load_data)
    );

    // result selection, WB payload and hazard/forwarding outputs
    always_comb begin
        final_result        = bus_q.res_from_mem ? load_data : bus_q.alu_result;
        wb_bus.syscall      = bus_q.syscall;
        wb_bus.ertn         = bus_q.ertn;
        wb_bus.pc           = bus_q.pc;
        wb_bus.gr_we        = bus_q.gr_we;
        wb_bus.dest         = bus_q.dest;
        wb_bus.final_result = final_result;
        ME_to_WB_Bus        = wb_bus;
        ME_dest             = bus_q.dest & {5{me_valid_q & bus_q.gr_we}};
`ifdef ME_LOAD_FWD_EN
        ME_Forward_Res      = final_result;
        ME_ld_block         = me_valid_q & bus_q.res_from_mem & !ready_go;
`else
        ME_Forward_Res      = bus_q.alu_result;
        ME_ld_block         = me_valid_q & bus_q.res_from_mem;
`endif
    end

endmodule
